saph_shape_assembler: RTL and testbench

Collects a stream of individual vertices into complete line, triangle and rectangle primitives and issues them to the rasterizer's shape-input handshake (`in_trig`/`in_type`/`in_shape`/`in_ready`). It sits between the command/vertex fetch stage and `saph_rasterizer`. It supports line and triangle strips, so that one new vertex per primitive suffices after a strip is started.

---
 rtl/saph_shape_assembler.sv | 146 ++++++++++++++
 tb/tb_saph_shape_assembler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saph_shape_assembler.sv
// saph_shape_assembler
// Gathers single vertices into line, triangle and rectangle primitives and
// hands each finished primitive to the rasterizer shape-input handshake.
// Line and triangle strips reuse the trailing vertices of the previous
// primitive, so only one new vertex is needed per strip primitive.

module saph_shape_assembler #(
  parameter int VW            = 32,
  parameter bit enable_strips = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_type,
  input  logic                cmd_strip,
  input  logic [VW-1:0]       cmd_vertex,
  output logic                shp_trig,
  output logic [1:0]          shp_type,
  output logic [3:0][VW-1:0]  shp_vertex,
  input  logic                shp_ready,
  output logic                err_type
);

  localparam logic [1:0] TYPE_LINE = 2'd0;
  localparam logic [1:0] TYPE_TRI  = 2'd1;
  localparam logic [1:0] TYPE_RES  = 2'd3;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_t;

  state_t               state;
  logic [2:0][VW-1:0]   vtx;
  logic [1:0]           cnt;
  logic [1:0]           typ;
  logic                 strip;
  logic                 parity;

  logic [1:0]           eff_type;
  logic [1:0]           need;
  logic [1:0]           cnt_inc;
  logic                 completes;
  logic                 reserved;
  logic [2:0][VW-1:0]   vtx_next;

  // Builds the four rasterizer slots; odd strip triangles swap the first two
  // slots so every triangle in a strip keeps the same winding.
  function automatic logic [3:0][VW-1:0] build_slots(
    input logic [2:0][VW-1:0] v,
    input logic [1:0]         t,
    input logic               p
  );
    logic [3:0][VW-1:0] s;
    s    = '0;
    s[0] = v[0];
    s[1] = v[1];
    if (t == TYPE_TRI) begin
      s[2] = v[2];
      if (p) begin
        s[0] = v[1];
        s[1] = v[0];
      end
    end
    return s;
  endfunction

  // Vertices are only taken while collecting and never while reset is held.
  assign cmd_ready = rst_n && (state == COLLECT);

  // Decode the incoming vertex: effective type, completion and the vertex set
  // as it will look once this vertex is stored.
  always_comb begin
    eff_type  = (cnt == 2'd0) ? cmd_type : typ;
    need      = (eff_type == TYPE_TRI) ? 2'd3 : 2'd2;
    cnt_inc   = cnt + 2'd1;
    completes = (cnt_inc == need);
    reserved  = (cnt == 2'd0) && (cmd_type == TYPE_RES);
    vtx_next  = vtx;
    vtx_next[cnt] = cmd_vertex;
  end

  // Collect/issue state machine with registered shape outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      vtx        <= '0;
      cnt        <= 2'd0;
      typ        <= TYPE_LINE;
      strip      <= 1'b0;
      parity     <= 1'b0;
      shp_trig   <= 1'b0;
      shp_type   <= 2'd0;
      shp_vertex <= '0;
      err_type   <= 1'b0;
    end else begin
      err_type <= 1'b0;
      case (state)
        COLLECT: begin
          if (cmd_valid) begin
            if (reserved) begin
              err_type <= 1'b1;
            end else begin
              vtx <= vtx_next;
              cnt <= cnt_inc;
              if (cnt == 2'd0) begin
                typ <= cmd_type;
              end
              if (completes) begin
                state      <= ISSUE;
                strip      <= enable_strips & cmd_strip;
                shp_trig   <= 1'b1;
                shp_type   <= eff_type;
                shp_vertex <= build_slots(vtx_next, eff_type, parity);
              end
            end
          end
        end
        ISSUE: begin
          if (shp_ready) begin
            state      <= COLLECT;
            shp_trig   <= 1'b0;
            shp_type   <= 2'd0;
            shp_vertex <= '0;
            if (strip && (typ == TYPE_LINE)) begin
              vtx[0] <= vtx[1];
              cnt    <= 2'd1;
            end else if (strip && (typ == TYPE_TRI)) begin
              vtx[0] <= vtx[1];
              vtx[1] <= vtx[2];
              cnt    <= 2'd2;
              parity <= ~parity;
            end else begin
              cnt    <= 2'd0;
              parity <= 1'b0;
              strip  <= 1'b0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_saph_shape_assembler.sv
// Bench for saph_shape_assembler: table-driven vertex stream with a shape
// scoreboard, plus hand sequences for backpressure, reserved types, reset
// and a second instance with strips disabled.

module tb_saph_shape_assembler;

  localparam int VW = 16;

  typedef logic [3:0][VW-1:0] slots_t;

  typedef struct {
    logic [1:0]  t;
    slots_t      s;
  } exp_t;

  typedef struct {
    logic [1:0]  typ;
    logic        strip;
    logic [VW-1:0] v;
    logic        push;
    logic [1:0]  etype;
    slots_t      eslots;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic          cmd_strip;
  logic [VW-1:0] cmd_vertex;
  logic          shp_trig;
  logic [1:0]    shp_type;
  slots_t        shp_vertex;
  logic          shp_ready;
  logic          err_type;

  logic          ns_valid;
  logic          ns_ready;
  logic [1:0]    ns_type;
  logic          ns_strip;
  logic [VW-1:0] ns_vertex;
  logic          ns_trig;
  logic [1:0]    ns_shp_type;
  slots_t        ns_shp_vertex;
  logic          ns_shp_ready;
  logic          ns_err;

  int   tests;
  int   failed;
  exp_t q[$];
  exp_t qn[$];
  vec_t vecs[$];

  saph_shape_assembler #(.VW(VW), .enable_strips(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_strip(cmd_strip), .cmd_vertex(cmd_vertex),
    .shp_trig(shp_trig), .shp_type(shp_type), .shp_vertex(shp_vertex),
    .shp_ready(shp_ready), .err_type(err_type)
  );

  saph_shape_assembler #(.VW(VW), .enable_strips(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(ns_valid), .cmd_ready(ns_ready), .cmd_type(ns_type),
    .cmd_strip(ns_strip), .cmd_vertex(ns_vertex),
    .shp_trig(ns_trig), .shp_type(ns_shp_type), .shp_vertex(ns_shp_vertex),
    .shp_ready(ns_shp_ready), .err_type(ns_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic slots_t mk(input logic [VW-1:0] a, b, c, d);
    slots_t s;
    s[0] = a;
    s[1] = b;
    s[2] = c;
    s[3] = d;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one vertex to the main instance once it is ready and records
  // the shape it should complete, if any.
  task automatic applyStimulus(input logic [1:0] t, input logic s, input logic [VW-1:0] v,
                               input logic push, input logic [1:0] et, input slots_t es);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      tests++;
      failed++;
      $display("[TB] FAIL cmd_ready timeout: got 0 expected 1");
      return;
    end
    cmd_type   = t;
    cmd_strip  = s;
    cmd_vertex = v;
    cmd_valid  = 1'b1;
    if (push) begin
      e.t = et;
      e.s = es;
      q.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Same as applyStimulus, for the instance with strips disabled.
  task automatic sendNs(input logic [1:0] t, input logic s, input logic [VW-1:0] v,
                        input logic push, input slots_t es);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!ns_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ns_ready) begin
      tests++;
      failed++;
      $display("[TB] FAIL ns cmd_ready timeout: got 0 expected 1");
      return;
    end
    ns_type   = t;
    ns_strip  = s;
    ns_vertex = v;
    ns_valid  = 1'b1;
    if (push) begin
      e.t = t;
      e.s = es;
      qn.push_back(e);
    end
    @(posedge clk);
    #1 ns_valid = 1'b0;
  endtask

  task automatic addVec(input logic [1:0] typ, input logic strip, input logic [VW-1:0] v,
                        input logic push, input logic [1:0] et, input slots_t es);
    vec_t r;
    r.typ = typ; r.strip = strip; r.v = v;
    r.push = push; r.etype = et; r.eslots = es;
    vecs.push_back(r);
  endtask

  // Scoreboard for the main instance: compare each shape on its handshake cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && shp_trig && shp_ready) begin
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected shape: got %h expected none", shp_vertex);
      end else begin
        e = q.pop_front();
        checkOutput("shape type", 64'(shp_type), 64'(e.t));
        checkOutput("shape slots", shp_vertex, e.s);
      end
    end
  end

  // Scoreboard for the strips-disabled instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ns_trig && ns_shp_ready) begin
      if (qn.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL ns unexpected shape: got %h expected none", ns_shp_vertex);
      end else begin
        e = qn.pop_front();
        checkOutput("ns shape type", 64'(ns_shp_type), 64'(e.t));
        checkOutput("ns shape slots", ns_shp_vertex, e.s);
      end
    end
  end

  initial begin
    int lowCycles;
    int waited;
    tests  = 0;
    failed = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_type = 2'd0; cmd_strip = 1'b0; cmd_vertex = '0;
    shp_ready = 1'b1;
    ns_valid = 1'b0; ns_type = 2'd0; ns_strip = 1'b0; ns_vertex = '0;
    ns_shp_ready = 1'b1;

    // Vector table: triangles, strips, ignored types, rectangles.
    addVec(2'd1, 1'b0, 16'h0011, 1'b0, 2'd0, '0);
    addVec(2'd1, 1'b0, 16'h0012, 1'b0, 2'd0, '0);
    addVec(2'd1, 1'b0, 16'h0013, 1'b1, 2'd1, mk(16'h0011, 16'h0012, 16'h0013, 16'h0000));
    addVec(2'd1, 1'b0, 16'h0021, 1'b0, 2'd0, '0);
    addVec(2'd3, 1'b0, 16'h0022, 1'b0, 2'd0, '0);
    addVec(2'd3, 1'b0, 16'h0023, 1'b1, 2'd1, mk(16'h0021, 16'h0022, 16'h0023, 16'h0000));
    addVec(2'd1, 1'b1, 16'h0031, 1'b0, 2'd0, '0);
    addVec(2'd1, 1'b1, 16'h0032, 1'b0, 2'd0, '0);
    addVec(2'd1, 1'b1, 16'h0033, 1'b1, 2'd1, mk(16'h0031, 16'h0032, 16'h0033, 16'h0000));
    addVec(2'd1, 1'b1, 16'h0034, 1'b1, 2'd1, mk(16'h0033, 16'h0032, 16'h0034, 16'h0000));
    addVec(2'd1, 1'b0, 16'h0035, 1'b1, 2'd1, mk(16'h0033, 16'h0034, 16'h0035, 16'h0000));
    addVec(2'd0, 1'b1, 16'h0041, 1'b0, 2'd0, '0);
    addVec(2'd0, 1'b1, 16'h0042, 1'b1, 2'd0, mk(16'h0041, 16'h0042, 16'h0000, 16'h0000));
    addVec(2'd0, 1'b1, 16'h0043, 1'b1, 2'd0, mk(16'h0042, 16'h0043, 16'h0000, 16'h0000));
    addVec(2'd0, 1'b0, 16'h0044, 1'b1, 2'd0, mk(16'h0043, 16'h0044, 16'h0000, 16'h0000));
    addVec(2'd2, 1'b1, 16'h0051, 1'b0, 2'd0, '0);
    addVec(2'd2, 1'b1, 16'h0052, 1'b1, 2'd2, mk(16'h0051, 16'h0052, 16'h0000, 16'h0000));
    addVec(2'd0, 1'b0, 16'h0053, 1'b0, 2'd0, '0);
    addVec(2'd0, 1'b0, 16'h0054, 1'b1, 2'd0, mk(16'h0053, 16'h0054, 16'h0000, 16'h0000));
    addVec(2'd1, 1'b1, 16'h0061, 1'b0, 2'd0, '0);
    addVec(2'd1, 1'b1, 16'h0062, 1'b0, 2'd0, '0);
    addVec(2'd1, 1'b1, 16'h0063, 1'b1, 2'd1, mk(16'h0061, 16'h0062, 16'h0063, 16'h0000));
    addVec(2'd0, 1'b0, 16'h0064, 1'b1, 2'd1, mk(16'h0063, 16'h0062, 16'h0064, 16'h0000));

    // Reset values while held in reset and just after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("reset shp_trig", 64'(shp_trig), 64'd0);
    checkOutput("reset err_type", 64'(err_type), 64'd0);
    checkOutput("reset shp_type", 64'(shp_type), 64'd0);
    checkOutput("reset shp_vertex", shp_vertex, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset", 64'(cmd_ready), 64'd1);

    // Single line: cmd_ready drops for exactly one cycle.
    applyStimulus(2'd0, 1'b0, 16'h00A1, 1'b0, 2'd0, '0);
    applyStimulus(2'd0, 1'b0, 16'h00B1, 1'b1, 2'd0, mk(16'h00A1, 16'h00B1, 16'h0000, 16'h0000));
    lowCycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      lowCycles++;
    end
    checkOutput("line ready-low cycles", 64'(lowCycles), 64'd1);

    // Triangle under backpressure: shape held stable for five stalled cycles.
    shp_ready = 1'b0;
    applyStimulus(2'd1, 1'b0, 16'h00A2, 1'b0, 2'd0, '0);
    applyStimulus(2'd1, 1'b0, 16'h00B2, 1'b0, 2'd0, '0);
    applyStimulus(2'd1, 1'b0, 16'h00C2, 1'b1, 2'd1, mk(16'h00A2, 16'h00B2, 16'h00C2, 16'h0000));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall shp_trig", 64'(shp_trig), 64'd1);
      checkOutput("stall cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("stall slots", shp_vertex, mk(16'h00A2, 16'h00B2, 16'h00C2, 16'h0000));
      @(posedge clk);
    end
    #1 shp_ready = 1'b1;

    // Reserved type is dropped with a one-cycle error pulse.
    applyStimulus(2'd3, 1'b0, 16'h00EE, 1'b0, 2'd0, '0);
    checkOutput("err_type pulse", 64'(err_type), 64'd1);
    checkOutput("ready after reserved", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 checkOutput("err_type clears", 64'(err_type), 64'd0);
    applyStimulus(2'd2, 1'b0, 16'h00A3, 1'b0, 2'd0, '0);
    applyStimulus(2'd2, 1'b0, 16'h00B3, 1'b1, 2'd2, mk(16'h00A3, 16'h00B3, 16'h0000, 16'h0000));

    // Table-driven vertex stream.
    foreach (vecs[i])
      applyStimulus(vecs[i].typ, vecs[i].strip, vecs[i].v, vecs[i].push, vecs[i].etype, vecs[i].eslots);

    // Reset during collection and again during issue.
    applyStimulus(2'd1, 1'b0, 16'h00A4, 1'b0, 2'd0, '0);
    applyStimulus(2'd1, 1'b0, 16'h00B4, 1'b0, 2'd0, '0);
    #2 rst_n = 1'b0;
    #1 checkOutput("mid reset cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    shp_ready = 1'b0;
    applyStimulus(2'd1, 1'b0, 16'h00A5, 1'b0, 2'd0, '0);
    applyStimulus(2'd1, 1'b0, 16'h00B5, 1'b0, 2'd0, '0);
    applyStimulus(2'd1, 1'b0, 16'h00C5, 1'b0, 2'd0, '0);
    @(negedge clk);
    checkOutput("issue before reset", 64'(shp_trig), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("issue reset shp_trig", 64'(shp_trig), 64'd0);
    checkOutput("issue reset shp_type", 64'(shp_type), 64'd0);
    checkOutput("issue reset shp_vertex", shp_vertex, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    shp_ready = 1'b1;
    applyStimulus(2'd0, 1'b0, 16'h00A6, 1'b0, 2'd0, '0);
    applyStimulus(2'd0, 1'b0, 16'h00B6, 1'b1, 2'd0, mk(16'h00A6, 16'h00B6, 16'h0000, 16'h0000));

    // Strips disabled: cmd_strip has no effect.
    sendNs(2'd0, 1'b1, 16'h0071, 1'b0, '0);
    sendNs(2'd0, 1'b1, 16'h0072, 1'b1, mk(16'h0071, 16'h0072, 16'h0000, 16'h0000));
    sendNs(2'd0, 1'b1, 16'h0073, 1'b0, '0);
    sendNs(2'd0, 1'b1, 16'h0074, 1'b1, mk(16'h0073, 16'h0074, 16'h0000, 16'h0000));
    sendNs(2'd1, 1'b1, 16'h0081, 1'b0, '0);
    sendNs(2'd1, 1'b1, 16'h0082, 1'b0, '0);
    sendNs(2'd1, 1'b1, 16'h0083, 1'b1, mk(16'h0081, 16'h0082, 16'h0083, 16'h0000));
    sendNs(2'd1, 1'b0, 16'h0084, 1'b0, '0);
    sendNs(2'd1, 1'b0, 16'h0085, 1'b0, '0);
    sendNs(2'd1, 1'b0, 16'h0086, 1'b1, mk(16'h0084, 16'h0085, 16'h0086, 16'h0000));

    // Let outstanding shapes drain and confirm nothing was lost.
    waited = 0;
    while ((q.size() != 0 || qn.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checkOutput("main shapes drained", 64'(q.size()), 64'd0);
    checkOutput("ns shapes drained", 64'(qn.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
